// File: rtl/conv1d_sequencer.sv
// 1-D FIR convolution sequencer: one sample in, one shared signed MAC stepped across all taps,
// result held on a valid/ready output. Coefficients are writable only while idle.
module conv1d_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned TAPS   = 4,
  parameter int unsigned ACC_W  = 2 * DATA_W + $clog2(TAPS) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [DATA_W-1:0]        coef_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_data,
  output logic                     busy
);

  localparam int unsigned IdxW  = $clog2(TAPS);
  localparam int unsigned ProdW = 2 * DATA_W;

  typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

  state_e                    state_q;
  logic signed [DATA_W-1:0]  win_q  [TAPS];
  logic signed [DATA_W-1:0]  coef_q [TAPS];
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic        [IdxW-1:0]    idx_q;
  logic signed [ProdW-1:0]   prod;

  always_comb begin
    prod  = win_q[idx_q] * coef_q[idx_q];
    acc_d = acc_q + {{(ACC_W - ProdW){prod[ProdW-1]}}, prod};
  end

  // All outputs decode from state or come straight from registers.
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StOut);
  assign busy      = (state_q != StIdle);
  assign out_data  = acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      idx_q   <= '0;
      for (int k = 0; k < TAPS; k++) begin
        win_q[k]  <= '0;
        coef_q[k] <= '0;
      end
    end else begin
      case (state_q)
        StIdle: begin
          // A coefficient write lands at the same edge as acceptance, ahead of the first MAC read.
          if (coef_we) coef_q[coef_addr] <= coef_data;
          if (in_valid) begin
            win_q[0] <= in_data;
            for (int k = 1; k < TAPS; k++) win_q[k] <= win_q[k-1];
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= StMac;
          end
        end
        StMac: begin
          acc_q <= acc_d;
          idx_q <= idx_q + IdxW'(1);
          if (idx_q == IdxW'(TAPS - 1)) state_q <= StOut;
        end
        StOut: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_conv1d_sequencer.sv
// Randomized self-checking bench for conv1d_sequencer against an array-based FIR model.
`timescale 1ns/1ps
module tb_conv1d_sequencer;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned TAPS   = 4;
  localparam int unsigned ACC_W  = 19;

  logic              clk = 1'b0;
  logic              rst;
  logic              coef_we;
  logic [1:0]        coef_addr;
  logic [DATA_W-1:0] coef_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: sample history (newest first) and coefficient table.
  int win_m  [TAPS];
  int coef_m [TAPS];

  conv1d_sequencer #(.DATA_W(DATA_W), .TAPS(TAPS), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int k = 0; k < TAPS; k++) begin
      win_m[k]  = 0;
      coef_m[k] = 0;
    end
  endfunction

  function automatic longint model_push(input int x);
    longint s = 0;
    for (int k = TAPS - 1; k > 0; k--) win_m[k] = win_m[k-1];
    win_m[0] = x;
    for (int k = 0; k < TAPS; k++) s += longint'(win_m[k]) * longint'(coef_m[k]);
    return s;
  endfunction

  // Called and returns on a falling edge.
  task automatic load_coef(input int addr, input int val);
    coef_we   = 1'b1;
    coef_addr = 2'(addr);
    coef_data = 8'(val);
    @(posedge clk);
    #1 coef_we = 1'b0;
    coef_m[addr] = int'($signed(8'(val)));
    @(negedge clk);
  endtask

  // Offers one sample, checks latency and result, optionally stalls the output for `stall`
  // cycles with a competing in_valid held, then completes the handshake.
  task automatic send(input int x, input bit cw, input int ca, input int cd, input bit mac_we,
                      input int stall, output longint got, output time t_acc);
    int     lat;
    bit     seen;
    longint exp;
    int     guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      $display("FAIL in_ready_timeout: got 0 expected 1");
      n_fail++;
      n_tests++;
    end
    in_valid  = 1'b1;
    in_data   = 8'(x);
    coef_we   = cw;
    coef_addr = 2'(ca);
    coef_data = 8'(cd);
    out_ready = (stall == 0);
    @(posedge clk);
    t_acc = $time;
    #1;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    if (cw) coef_m[ca] = int'($signed(8'(cd)));
    exp = model_push(int'($signed(8'(x))));
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (mac_we && lat == 1) begin
        coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'd5;
      end
      if (lat == 2) begin
        coef_we = 1'b0;
        check("mac_busy", busy, 1);
        check("mac_in_ready", in_ready, 0);
      end
      if (out_valid) seen = 1'b1;
    end
    check("latency", lat, TAPS);
    got = longint'($signed(out_data));
    check("result", got, exp);
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      in_data  = 8'(~x);
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_data", longint'($signed(out_data)), got);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
    check("post_busy", busy, 0);
  endtask

  initial begin
    longint got;
    time    t0, t1;
    int     imp[4] = '{1, 2, 3, 4};

    rst = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);

    // Impulse response and acceptance spacing.
    for (int k = 0; k < TAPS; k++) load_coef(k, k + 1);
    send(1, 0, 0, 0, 0, 0, got, t0);
    check("imp0", got, 1);
    for (int k = 1; k < TAPS; k++) begin
      send(0, 0, 0, 0, 0, 0, got, t1);
      check("imp", got, imp[k]);
      check("gap", longint'((t1 - t0) / 10), TAPS + 2);
      t0 = t1;
    end

    // Signed extremes.
    for (int k = 0; k < TAPS; k++) load_coef(k, -128);
    for (int k = 0; k < TAPS; k++) send(-128, 0, 0, 0, 0, 0, got, t0);
    check("ext_pos", got, 65536);
    for (int k = 0; k < TAPS; k++) load_coef(k, 127);
    for (int k = 0; k < TAPS; k++) send(-128, 0, 0, 0, 0, 0, got, t0);
    check("ext_neg", got, -65024);

    // Back-pressure with a competing sample held.
    for (int k = 0; k < TAPS; k++) load_coef(k, k + 1);
    send(3, 0, 0, 0, 0, 5, got, t0);
    send(2, 0, 0, 0, 0, 0, got, t0);

    // Coefficient lockout during MAC, then the same write in IDLE.
    send(10, 0, 0, 0, 1, 0, got, t0);
    load_coef(0, 5);
    send(1, 0, 0, 0, 0, 0, got, t0);
    // Write coinciding with acceptance must be seen by this convolution.
    send(4, 1, 1, -7, 0, 0, got, t0);

    // Reset mid-MAC.
    in_valid = 1'b1; in_data = 8'd9;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_in_ready", in_ready, 1);
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_out_data", out_data, 0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    begin
      int vcount = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (out_valid) vcount++;
      end
      check("no_valid_after_rst", vcount, 0);
    end
    load_coef(0, 1);
    for (int k = 1; k < TAPS; k++) load_coef(k, 0);
    send(7, 0, 0, 0, 0, 0, got, t0);
    check("after_rst", got, 7);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      if (n % 8 == 0)
        for (int k = 0; k < TAPS; k++) load_coef(k, int'($signed(8'($urandom))));
      send(int'($signed(8'($urandom))), 1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
           int'($signed(8'($urandom))), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
           got, t0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
